// File: rtl/countdown_display_scanner.sv
// MM:SS BCD countdown with 4-digit time-multiplexed display feed.
// Shows "Erro" on the display while in the error state.
module countdown_display_scanner #(
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] preset_mm,
    input  logic [7:0] preset_ss,
    input  logic       start,
    input  logic       pause,
    input  logic       fault,
    input  logic       clear,
    output logic [3:0] data,
    output logic [3:0] digit_sel,
    output logic       running,
    output logic       done,
    output logic       error
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    localparam logic [3:0] CH_E = 4'b1011;
    localparam logic [3:0] CH_R = 4'b1100;
    localparam logic [3:0] CH_O = 4'b1101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state, nstate;
    logic [15:0]   cnt, ncnt;
    logic [TW-1:0] tick, ntick;
    logic [SW-1:0] scan, nscan;
    logic [1:0]    idx, nidx;
    logic          pulse;
    logic          preset_ok;
    logic [3:0]    ndata;

    function automatic logic [15:0] dec_bcd(input logic [15:0] c);
        logic [3:0] mt, mu, st, su;
        {mt, mu, st, su} = c;
        if (c != 16'h0000) begin
            if (su != 4'd0) su = su - 4'd1;
            else begin
                su = 4'd9;
                if (st != 4'd0) st = st - 4'd1;
                else begin
                    st = 4'd5;
                    if (mu != 4'd0) mu = mu - 4'd1;
                    else begin
                        mu = 4'd9;
                        mt = mt - 4'd1;
                    end
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

    assign preset_ok = (preset_mm[7:4] <= 4'd9) && (preset_mm[3:0] <= 4'd9)
                    && (preset_ss[7:4] <= 4'd5) && (preset_ss[3:0] <= 4'd9);

    // Events are considered in priority order; the first one that applies wins.
    always_comb begin
        nstate = state;
        ncnt   = cnt;
        ntick  = tick;
        pulse  = 1'b0;
        if (fault) begin
            nstate = S_ERROR;
        end else if (clear && (state == S_ERROR || state == S_DONE)) begin
            nstate = S_IDLE;
            ncnt   = 16'h0000;
        end else if (load && (state == S_IDLE || state == S_PAUSED
                              || state == S_DONE)) begin
            if (preset_ok) begin
                ncnt   = {preset_mm, preset_ss};
                ntick  = '0;
                nstate = S_IDLE;
            end else begin
                nstate = S_ERROR;
            end
        end else if (start && (state == S_IDLE || state == S_PAUSED)) begin
            if (cnt == 16'h0000) begin
                nstate = S_DONE;
                pulse  = 1'b1;
            end else begin
                nstate = S_RUN;
                if (state == S_IDLE) ntick = '0;
            end
        end else if (pause && state == S_RUN) begin
            nstate = S_PAUSED;
        end else if (state == S_RUN) begin
            if (tick == TICK_LAST) begin
                ntick = '0;
                ncnt  = dec_bcd(cnt);
                if (cnt == 16'h0001) begin
                    nstate = S_DONE;
                    pulse  = 1'b1;
                end
            end else begin
                ntick = tick + TW'(1);
            end
        end
    end

    always_comb begin
        nscan = (scan == SCAN_LAST) ? '0 : scan + SW'(1);
        nidx  = (scan == SCAN_LAST) ? idx - 2'd1 : idx;
        ndata = ncnt[{nidx, 2'b00} +: 4];
        if (nstate == S_ERROR) begin
            unique case (nidx)
                2'd3:    ndata = CH_E;
                2'd2:    ndata = CH_R;
                2'd1:    ndata = CH_R;
                default: ndata = CH_O;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= 16'h0000;
            tick      <= '0;
            scan      <= '0;
            idx       <= 2'd3;
            data      <= 4'b0000;
            digit_sel <= 4'b0111;
            running   <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= nstate;
            cnt       <= ncnt;
            tick      <= ntick;
            scan      <= nscan;
            idx       <= nidx;
            data      <= ndata;
            digit_sel <= ~(4'b0001 << nidx);
            running   <= (nstate == S_RUN);
            done      <= pulse;
            error     <= (nstate == S_ERROR);
        end
    end

endmodule

// File: tb/tb_countdown_display_scanner.sv
// Scoreboard bench: stimulus queues expected scan slots and done-pulse cycles,
// a monitor pops and compares as the DUT presents them.
module tb_countdown_display_scanner;

    logic       clock;
    logic       reset_n;
    logic       load;
    logic [7:0] preset_mm;
    logic [7:0] preset_ss;
    logic       start;
    logic       pause;
    logic       fault;
    logic       clear;
    logic [3:0] data;
    logic [3:0] digit_sel;
    logic       running;
    logic       done;
    logic       error;

    countdown_display_scanner #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
        .clock(clock), .reset_n(reset_n), .load(load),
        .preset_mm(preset_mm), .preset_ss(preset_ss),
        .start(start), .pause(pause), .fault(fault), .clear(clear),
        .data(data), .digit_sel(digit_sel), .running(running),
        .done(done), .error(error)
    );

    typedef struct {
        logic [3:0] sel;
        logic [3:0] data;
        logic       err;
    } scan_t;

    scan_t      sq[$];
    int         dq[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [3:0] prev_sel = 4'b0111;
    bit         aligned = 0;
    scan_t      se;
    int         de;
    int         c0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: done pulses and scan slot changes.
    always @(negedge clock) begin
        if (done) begin
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: done=1 at cycle %0d, required 0", cyc);
            end else begin
                de = dq.pop_front();
                if (de != cyc) begin
                    errors++;
                    $display("FAIL done_cycle: done at cycle %0d, required %0d", cyc, de);
                end
            end
        end
        if (digit_sel != prev_sel && sq.size() > 0) begin
            if (!aligned && digit_sel == sq[0].sel) aligned = 1;
            if (aligned) begin
                se = sq.pop_front();
                checks++;
                if ({digit_sel, data, error} !== {se.sel, se.data, se.err}) begin
                    errors++;
                    $display("FAIL scan_slot: sel=%b data=%h err=%b, required sel=%b data=%h err=%b",
                             digit_sel, data, error, se.sel, se.data, se.err);
                end
                if (sq.size() == 0) aligned = 0;
            end
        end
        prev_sel = digit_sel;
    end

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic push_scan(input logic [3:0] d3, input logic [3:0] d2,
                             input logic [3:0] d1, input logic [3:0] d0,
                             input logic err);
        sq.push_back('{4'b0111, d3, err});
        sq.push_back('{4'b1011, d2, err});
        sq.push_back('{4'b1101, d1, err});
        sq.push_back('{4'b1110, d0, err});
    endtask

    task automatic wait_scan(input string name);
        for (int i = 0; i < 60 && sq.size() > 0; i++) @(negedge clock);
        checks++;
        if (sq.size() > 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d scan slots pending, required 0", name, sq.size());
            sq.delete();
            aligned = 0;
        end
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 40 && dq.size() > 0; i++) @(negedge clock);
        checks++;
        if (dq.size() > 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d done pulses pending, required 0", name, dq.size());
            dq.delete();
        end
    endtask

    task automatic do_load(input logic [7:0] mm, input logic [7:0] ss);
        preset_mm = mm;
        preset_ss = ss;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_sel"}, digit_sel, 4'b0111);
        chk({name, "_data"}, data, 4'h0);
        chk({name, "_running"}, {3'b0, running}, 4'h0);
        chk({name, "_done"}, {3'b0, done}, 4'h0);
        chk({name, "_error"}, {3'b0, error}, 4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        load = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        fault = 1'b0;
        clear = 1'b0;
        preset_mm = 8'h00;
        preset_ss = 8'h00;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        chk_reset_vals("reset");

        // Test 1: 00:03 counts down to done at edge 12 after start.
        do_load(8'h00, 8'h03);
        c0 = cyc;
        dq.push_back(c0 + 13);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("t1_running", {3'b0, running}, 4'h1);
        repeat (12) @(negedge clock);
        chk("t1_running_done", {3'b0, running}, 4'h0);
        @(negedge clock);
        chk("t1_done_cleared", {3'b0, done}, 4'h0);
        wait_done("t1_done");
        push_scan(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        wait_scan("t1_scan");

        // Test 2: 10:00 -> 09:59 after one tick, then paused for display.
        do_load(8'h10, 8'h00);
        do_start();
        chk("t2_running", {3'b0, running}, 4'h1);
        repeat (4) @(negedge clock);
        pause = 1'b1;
        @(negedge clock);
        pause = 1'b0;
        chk("t2_paused", {3'b0, running}, 4'h0);
        push_scan(4'h0, 4'h9, 4'h5, 4'h9, 1'b0);
        wait_scan("t2_scan");

        // Test 3: invalid preset forces Erro; load/start ignored until clear.
        do_load(8'h00, 8'h60);
        chk("t3_error", {3'b0, error}, 4'h1);
        push_scan(4'hB, 4'hC, 4'hC, 4'hD, 1'b1);
        wait_scan("t3_scan_err");
        do_load(8'h00, 8'h05);
        do_start();
        @(negedge clock);
        chk("t3_error_held", {3'b0, error}, 4'h1);
        chk("t3_not_running", {3'b0, running}, 4'h0);
        do_clear();
        chk("t3_error_cleared", {3'b0, error}, 4'h0);
        push_scan(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        wait_scan("t3_scan_zero");

        // Test 4: fault beats clear and start in the same cycle.
        do_load(8'h00, 8'h40);
        do_start();
        chk("t4_running", {3'b0, running}, 4'h1);
        fault = 1'b1;
        clear = 1'b1;
        start = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        start = 1'b0;
        chk("t4_error", {3'b0, error}, 4'h1);
        chk("t4_not_running", {3'b0, running}, 4'h0);
        do_clear();
        chk("t4_clear_under_fault", {3'b0, error}, 4'h1);
        fault = 1'b0;
        @(negedge clock);
        chk("t4_error_sticky", {3'b0, error}, 4'h1);
        do_clear();
        chk("t4_error_cleared", {3'b0, error}, 4'h0);
        push_scan(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        wait_scan("t4_scan_zero");

        // Test 5: pause at prescaler 2 keeps it; decrement 2 edges after resume.
        do_load(8'h00, 8'h01);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        pause = 1'b1;
        @(negedge clock);
        pause = 1'b0;
        chk("t5_paused", {3'b0, running}, 4'h0);
        repeat (20) @(negedge clock);
        push_scan(4'h0, 4'h0, 4'h0, 4'h1, 1'b0);
        wait_scan("t5_scan_hold");
        c0 = cyc;
        dq.push_back(c0 + 3);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("t5_resumed", {3'b0, running}, 4'h1);
        repeat (2) @(negedge clock);
        chk("t5_done_state", {3'b0, running}, 4'h0);
        wait_done("t5_done");
        do_clear();
        c0 = cyc;
        dq.push_back(c0 + 1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        wait_done("t5_zero_start");

        // Test 6: async reset mid-RUN clears outputs without a clock edge.
        do_load(8'h00, 8'h03);
        do_start();
        repeat (2) @(negedge clock);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("t6_async");
        repeat (20) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("t6_running", {3'b0, running}, 4'h0);
        chk("t6_error", {3'b0, error}, 4'h0);
        repeat (12) @(negedge clock);
        chk("t6_idle", {3'b0, running}, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
